// File: rtl/efuse_pkg.sv
// Shared types and constants for the EFUSE macro responder model.
package efuse_pkg;

    localparam int FUSE_BITS  = 256;
    localparam int FUSE_BYTES = 32;
    localparam int NUM_FLAGS  = 5;

    // Bit positions inside viol_flags.
    localparam int VF_SETUP = 0;
    localparam int VF_TPGM  = 1;
    localparam int VF_TRD   = 2;
    localparam int VF_MODE  = 3;
    localparam int VF_ADDR  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PGM_SU,
        ST_PGM_ACT,
        ST_RD_SU,
        ST_RD_ACT
    } state_t;

endpackage

// File: rtl/efuse_macro_model_if.sv
// Access bus between the efuse controller (master) and the fuse macro (slave).
interface efuse_macro_model_if;

    logic       efuse_pgmen_i;
    logic       efuse_rden_i;
    logic       efuse_aen_i;
    logic [7:0] efuse_addr_i;
    logic [7:0] efuse_rdata_o;

    modport master (
        output efuse_pgmen_i, efuse_rden_i, efuse_aen_i, efuse_addr_i,
        input  efuse_rdata_o
    );

    modport slave (
        input  efuse_pgmen_i, efuse_rden_i, efuse_aen_i, efuse_addr_i,
        output efuse_rdata_o
    );

endinterface

// File: rtl/efuse_pulse_meter.sv
// aen edge detector plus a saturating counter of the current aen-high width.
module efuse_pulse_meter #(
    parameter int unsigned CW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          aen,
    output logic          rise,
    output logic          fall,
    output logic [CW-1:0] width
);

    logic aen_q;

    assign rise = aen & ~aen_q;
    assign fall = ~aen & aen_q;

    // width keeps the length of the last pulse until the next rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aen_q <= 1'b0;
            width <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            aen_q <= aen;
            if (rise) begin
                width <= CW'(1);
            end else if (aen && (width != '1)) begin
                width <= width + CW'(1);
            end
        end
    end

endmodule

// File: rtl/efuse_macro_model.sv
// Cycle-based responder model of the 256-bit OTP efuse macro with protocol checking.
module efuse_macro_model
    import efuse_pkg::*;
#(
    parameter int unsigned          TSU_CYC      = 2,
    parameter int unsigned          MIN_TPGM_CYC = 8,
    parameter int unsigned          MIN_TRD_CYC  = 2,
    parameter int unsigned          CW           = 10,
    parameter logic [FUSE_BITS-1:0] INIT_VAL     = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    efuse_macro_model_if.slave   bus,
    input  logic                 fuse_preload,
    input  logic                 viol_clr,
    output logic [NUM_FLAGS-1:0] viol_flags,
    output logic [8:0]           pgm_count,
    output logic [FUSE_BITS-1:0] fuse_array_o
);

    localparam logic [CW-1:0] TSU_W  = CW'(TSU_CYC);
    localparam logic [CW-1:0] TPGM_W = CW'(MIN_TPGM_CYC);
    localparam logic [CW-1:0] TRD_W  = CW'(MIN_TRD_CYC);

    state_t                        state, state_nxt;
    logic [CW-1:0]                 su_cnt, su_cnt_nxt;
    logic [7:0]                    addr_q, addr_nxt;
    logic                          op_bad, op_bad_nxt;
    logic [7:0]                    rdata_q, rdata_nxt;
    logic [NUM_FLAGS-1:0]          flag_set;
    logic                          fuse_wr;
    logic [FUSE_BITS-1:0]          fuse_q;
    logic [$clog2(FUSE_BYTES)-1:0] rd_byte;

    logic          pgmen, rden, is_pgm, own_en;
    logic          rise, fall;
    logic [CW-1:0] width;

    assign pgmen  = bus.efuse_pgmen_i;
    assign rden   = bus.efuse_rden_i;
    assign is_pgm = (state == ST_PGM_SU) || (state == ST_PGM_ACT);
    assign own_en = is_pgm ? pgmen : rden;
    assign rd_byte = addr_q[7:3];

    efuse_pulse_meter #(.CW(CW)) u_meter (
        .clk   (clk),
        .rst_n (rst_n),
        .aen   (bus.efuse_aen_i),
        .rise  (rise),
        .fall  (fall),
        .width (width)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt  = state;
        su_cnt_nxt = su_cnt;
        addr_nxt   = addr_q;
        op_bad_nxt = op_bad;
        rdata_nxt  = rdata_q;
        flag_set   = '0;
        fuse_wr    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if ((pgmen && rden) || rise) begin
                    flag_set[VF_MODE] = 1'b1;
                end else if (pgmen) begin
                    state_nxt  = ST_PGM_SU;
                    su_cnt_nxt = CW'(1);
                end else if (rden) begin
                    state_nxt  = ST_RD_SU;
                    su_cnt_nxt = CW'(1);
                end
            end
            ST_PGM_SU, ST_RD_SU: begin
                if (su_cnt != '1) su_cnt_nxt = su_cnt + CW'(1);
                if (pgmen && rden) begin
                    flag_set[VF_MODE] = 1'b1;
                    state_nxt         = ST_IDLE;
                end else if (!own_en) begin
                    state_nxt = ST_IDLE;
                end else if (rise) begin
                    state_nxt          = is_pgm ? ST_PGM_ACT : ST_RD_ACT;
                    addr_nxt           = bus.efuse_addr_i;
                    op_bad_nxt         = (su_cnt < TSU_W);
                    flag_set[VF_SETUP] = (su_cnt < TSU_W);
                end
            end
            ST_PGM_ACT, ST_RD_ACT: begin
                if (!own_en) begin
                    // Enable pulled out from under an active strobe: abort without writing.
                    flag_set[VF_MODE] = 1'b1;
                    state_nxt         = ST_IDLE;
                end else if (fall) begin
                    state_nxt  = is_pgm ? ST_PGM_SU : ST_RD_SU;
                    su_cnt_nxt = CW'(1);
                    if (is_pgm) begin
                        flag_set[VF_TPGM] = (width < TPGM_W);
                        fuse_wr           = (width >= TPGM_W) && !op_bad;
                    end else begin
                        flag_set[VF_TRD] = (width < TRD_W);
                    end
                end else begin
                    if (bus.efuse_addr_i != addr_q) begin
                        flag_set[VF_ADDR] = 1'b1;
                        op_bad_nxt        = 1'b1;
                    end
                    // width is about to reach MIN_TRD_CYC on this edge.
                    if (!is_pgm && !op_bad_nxt && (width == TRD_W - CW'(1))) begin
                        rdata_nxt = fuse_q[{rd_byte, 3'b000} +: 8];
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            su_cnt     <= '0;
            addr_q     <= '0;
            op_bad     <= 1'b0;
            rdata_q    <= '0;
            viol_flags <= '0;
            pgm_count  <= '0;
        end else begin
            state      <= state_nxt;
            su_cnt     <= su_cnt_nxt;
            addr_q     <= addr_nxt;
            op_bad     <= op_bad_nxt;
            rdata_q    <= rdata_nxt;
            viol_flags <= (viol_clr ? '0 : viol_flags) | flag_set;
            if (fuse_wr && (pgm_count != 9'h1FF)) pgm_count <= pgm_count + 9'd1;
        end
    end

    // NOTE: the fuse array is deliberately left out of reset; it models non-volatile storage.
    always_ff @(posedge clk) begin
        if (fuse_preload) begin
            fuse_q <= INIT_VAL;
        end else if (fuse_wr && rst_n) begin
            fuse_q[addr_q] <= 1'b1;
        end
    end

    assign bus.efuse_rdata_o = rdata_q;
    assign fuse_array_o      = fuse_q;

endmodule

// File: tb/tb_efuse_macro_model.sv
// Randomized self-checking bench for efuse_macro_model against an operation-level model.
module tb_efuse_macro_model;
    import efuse_pkg::*;

    localparam int TSU  = 2;
    localparam int TPGM = 8;
    localparam int TRD  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 fuse_preload = 1'b0;
    logic                 viol_clr = 1'b0;
    logic [NUM_FLAGS-1:0] viol_flags;
    logic [8:0]           pgm_count;
    logic [FUSE_BITS-1:0] fuse_array_o;

    efuse_macro_model_if bus ();

    efuse_macro_model dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .fuse_preload (fuse_preload),
        .viol_clr     (viol_clr),
        .viol_flags   (viol_flags),
        .pgm_count    (pgm_count),
        .fuse_array_o (fuse_array_o)
    );

    always #5 clk = ~clk;

    // Reference model state, updated per operation from the protocol rules.
    logic [FUSE_BITS-1:0] m_fuse;
    logic [NUM_FLAGS-1:0] m_flags;
    logic [8:0]           m_count;
    logic [7:0]           m_rdata;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic pg, input logic rd, input logic ae, input logic [7:0] ad,
                         input logic clr);
        @(negedge clk);
        bus.efuse_pgmen_i = pg;
        bus.efuse_rden_i  = rd;
        bus.efuse_aen_i   = ae;
        bus.efuse_addr_i  = ad;
        viol_clr          = clr;
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".flags"}, 256'(viol_flags), 256'(m_flags));
        check({tag, ".count"}, 256'(pgm_count), 256'(m_count));
        check({tag, ".rdata"}, 256'(bus.efuse_rdata_o), 256'(m_rdata));
        check({tag, ".fuse"}, fuse_array_o, m_fuse);
    endtask

    // One complete access: su enable-only cycles, n aen-high cycles, fall, enable drop.
    // glitch_k (2..n) changes addr on that aen-high cycle; clr_fall pulses viol_clr on the fall.
    task automatic run_op(input string tag, input bit is_pgm, input int su, input int n,
                          input logic [7:0] ad, input int glitch_k, input bit clr_fall);
        bit         bad;
        bit         upd;
        logic [7:0] byte_v;
        logic [7:0] a_j;
        logic [7:0] mid_exp;

        bad    = (su < TSU);
        byte_v = m_fuse[{ad[7:3], 3'b000} +: 8];
        upd    = !is_pgm && !bad && (n >= TRD) && (glitch_k != TRD);
        if (bad) m_flags[VF_SETUP] = 1'b1;
        if (glitch_k >= 2 && glitch_k <= n) begin
            m_flags[VF_ADDR] = 1'b1;
            bad              = 1'b1;
        end

        for (int s = 0; s < su; s++) drive(is_pgm, !is_pgm, 1'b0, ad, 1'b0);
        for (int j = 1; j <= n; j++) begin
            a_j = (j == glitch_k) ? (ad ^ 8'h01) : ad;
            drive(is_pgm, !is_pgm, 1'b1, a_j, 1'b0);
            if (!is_pgm && j == TRD) begin
                sample();
                mid_exp = upd ? byte_v : m_rdata;
                check({tag, ".rd_mid"}, 256'(bus.efuse_rdata_o), 256'(mid_exp));
            end
        end
        drive(is_pgm, !is_pgm, 1'b0, ad, clr_fall);
        drive(1'b0, 1'b0, 1'b0, ad, 1'b0);
        sample();

        if (clr_fall) m_flags = '0;
        if (is_pgm) begin
            if (n < TPGM) begin
                m_flags[VF_TPGM] = 1'b1;
            end else if (!bad) begin
                m_fuse[ad] = 1'b1;
                if (m_count != 9'd511) m_count = m_count + 9'd1;
            end
        end else begin
            if (n < TRD) m_flags[VF_TRD] = 1'b1;
            if (upd) m_rdata = byte_v;
        end
        check_state(tag);
    endtask

    task automatic clear_flags();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        sample();
        m_flags = '0;
        check("clr.flags", 256'(viol_flags), 256'(m_flags));
    endtask

    task automatic both_enables();
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        sample();
        m_flags[VF_MODE] = 1'b1;
        check_state("both_en");
    endtask

    task automatic idle_aen_rise();
        drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        sample();
        m_flags[VF_MODE] = 1'b1;
        check_state("idle_aen");
    endtask

    task automatic abort_pgm(input logic [7:0] ad);
        for (int s = 0; s < 2; s++) drive(1'b1, 1'b0, 1'b0, ad, 1'b0);
        for (int j = 0; j < 9; j++) drive(1'b1, 1'b0, 1'b1, ad, 1'b0);
        drive(1'b0, 1'b0, 1'b1, ad, 1'b0);
        drive(1'b0, 1'b0, 1'b0, ad, 1'b0);
        sample();
        m_flags[VF_MODE] = 1'b1;
        check_state("abort");
    endtask

    task automatic reset_mid_pgm(input logic [7:0] ad);
        for (int s = 0; s < 2; s++) drive(1'b1, 1'b0, 1'b0, ad, 1'b0);
        for (int j = 0; j < 4; j++) drive(1'b1, 1'b0, 1'b1, ad, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, ad, 1'b0);
        rst_n = 1'b1;
        sample();
        m_flags = '0;
        m_count = '0;
        m_rdata = '0;
        check_state("rst_mid");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bit         rp;
        int         su;
        int         n;
        int         gk;
        bit         clr;
        logic [7:0] ad;

        bus.efuse_pgmen_i = 1'b0;
        bus.efuse_rden_i  = 1'b0;
        bus.efuse_aen_i   = 1'b0;
        bus.efuse_addr_i  = 8'h00;
        m_flags = '0;
        m_count = '0;
        m_rdata = '0;
        m_fuse  = '0;

        repeat (3) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        sample();
        check("reset.flags", 256'(viol_flags), 256'(0));
        check("reset.count", 256'(pgm_count), 256'(0));
        check("reset.rdata", 256'(bus.efuse_rdata_o), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        fuse_preload = 1'b1;
        @(negedge clk);
        fuse_preload = 1'b0;
        check("preload.fuse", fuse_array_o, m_fuse);

        // Directed scenarios.
        run_op("pgm_13", 1'b1, 2, 8, 8'h13, 0, 1'b0);
        check("pgm_13.bit19", 256'(fuse_array_o[19]), 256'(1));
        run_op("rd_10", 1'b0, 2, 2, 8'h10, 0, 1'b0);
        check("rd_10.byte", 256'(bus.efuse_rdata_o), 256'(8'h08));
        run_op("pgm_short", 1'b1, 2, 7, 8'h20, 0, 1'b0);
        clear_flags();
        run_op("rd_setup", 1'b0, 1, 2, 8'h10, 0, 1'b0);
        both_enables();
        run_op("pgm_after_mode", 1'b1, 2, 8, 8'h07, 0, 1'b0);
        run_op("pgm_glitch", 1'b1, 2, 8, 8'h40, 3, 1'b0);
        idle_aen_rise();
        abort_pgm(8'h41);
        clear_flags();
        both_enables();
        run_op("clr_vs_set", 1'b1, 2, 7, 8'h21, 0, 1'b1);
        run_op("rd_glitch2", 1'b0, 3, 3, 8'h00, 2, 1'b0);
        run_op("rd_one", 1'b0, 2, 1, 8'h00, 0, 1'b0);
        reset_mid_pgm(8'h55);
        run_op("pgm_55", 1'b1, 2, 8, 8'h55, 0, 1'b0);
        run_op("rd_55", 1'b0, 2, 2, 8'h55, 0, 1'b0);

        // Randomized mix of programs and reads, clustered on the low fuse bytes.
        for (int i = 0; i < 150; i++) begin
            rp  = 1'($urandom_range(0, 1));
            su  = $urandom_range(1, 3);
            n   = rp ? $urandom_range(6, 10) : $urandom_range(1, 4);
            ad  = 8'($urandom_range(0, 63));
            gk  = ($urandom_range(0, 4) == 0 && n >= 2) ? $urandom_range(2, n) : 0;
            clr = ($urandom_range(0, 7) == 0);
            run_op("rand", rp, su, n, ad, gk, clr);
        end

        // Drive pgm_count into saturation.
        for (int i = 0; i < 515; i++) begin
            ad = 8'($urandom_range(0, 255));
            run_op("sat", 1'b1, 2, 8, ad, 0, 1'b0);
        end
        check("count_sat", 256'(pgm_count), 256'(511));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
